complex_div: RTL
================

COMPLEX_DIV -- requirements
Module: complex_div

Interface
REQ-001 Parameter: W, default 20, width of every complex component; Q1.(W-1) fractional format; full scale is 2^(W-1).
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a_in/b_in are valid this cycle.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a_in_i, a_in_q  input  W each  dividend real/imag, signed.
REQ-007 b_in_i, b_in_q  input  W each  divisor real/imag, signed.
REQ-008 out_i, out_q  output  W each  quotient real/imag, signed Q1.(W-1).
REQ-009 out_valid  output  1  one-cycle pulse; out_i/out_q/sat/div_zero are valid.
REQ-010 sat  output  1  at least one output component was saturated.
REQ-011 div_zero  output  1  divisor was 0+j0.

Function
REQ-012 The block SHALL compute out = a/b = a*conj(b)/|b|^2, scaled by 2^(W-1), which is the inverse of the team's Q1.(W-1) complex multiplier.
REQ-013 FSM states SHALL be IDLE, MULT, SUM, DIV and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept: in_valid=1 with in_ready=1 at an edge SHALL register the operands and go to MULT; in_valid in any other state SHALL be ignored.
REQ-015 MULT SHALL register the four 2W-bit signed products ai*bi, aq*bq, aq*bi and ai*bq, then go to SUM.
REQ-016 SUM SHALL register the following, then go to DIV:
- num_i = ai*bi + aq*bq and num_q = aq*bi - ai*bq, each 2W+1 bits signed;
- den = bi^2 + bq^2, 2W bits unsigned;
- the magnitudes and signs of num_i and num_q;
- a zero flag (den == 0);
- per-component overflow flags (|num| >= 2*den).
REQ-017 DIV SHALL run restoring division on the magnitudes, one quotient bit per component per cycle, for W cycles, giving Q = floor(|num|*2^(W-1)/den), then go to DONE.
REQ-018 Sign SHALL be applied after division, so truncation is toward zero.
REQ-019 Saturation: positive results with Q > 2^(W-1)-1, or with the overflow flag set, SHALL output 2^(W-1)-1; negative results with Q > 2^(W-1), or with the overflow flag set, SHALL output -2^(W-1); sat SHALL be 1 if either component saturates.
REQ-020 Divisor 0+j0: out_i=out_q=0, sat=0, div_zero=1, with the same latency as a normal division.
REQ-021 DONE SHALL register the outputs, assert out_valid for exactly one cycle and return to IDLE at the next edge.
REQ-022 Latency from the accept edge to the out_valid cycle SHALL be W+3 clocks; back-to-back throughput SHALL be one result per W+4 clocks.
REQ-023 out_i, out_q, sat and div_zero SHALL hold their value until the next DONE.

Reset
REQ-024 While reset=1, the block SHALL be in IDLE with out_i=out_q=0, out_valid=0, sat=0 and div_zero=0; in_ready SHALL be 1, but inputs SHALL be ignored until reset deasserts.
REQ-025 Reset asserted in any state SHALL abort the operation in progress with no out_valid pulse; the first accept after release SHALL compute correctly.

Configuration
REQ-026 Macro COMPLEX_DIV_RND_EN defined: DIV SHALL run W+1 cycles and round |Q| half away from zero before sign and saturation; latency W+4, throughput one per W+5 clocks.
REQ-027 COMPLEX_DIV_RND_EN undefined: truncation toward zero, with the latency and throughput of REQ-022.

Verification (W=20)
REQ-028 a=(131072,0), b=(262144,0) -> after 23 clocks out_valid=1, out=(262144,0), sat=0, div_zero=0.
REQ-029 a=(131072,0), b=(0,262144) -> out=(0,-262144); a=(0,131072), b=(0,262144) -> out=(262144,0).
REQ-030 a=(262144,0), b=(131072,0) -> out=(524287,0), sat=1; a=(-262144,0), same b -> out=(-524288,0), sat=1.
REQ-031 b=(0,0), any a -> out=(0,0), div_zero=1, sat=0, out_valid after 23 clocks.
REQ-032 a=(1,0), b=(3,0) -> out_i=174762 without the macro; out_i=174763 with COMPLEX_DIV_RND_EN, at 24 clocks.
REQ-033 Reset pulsed during DIV -> no out_valid pulse, outputs 0, in_ready=1 after release; rerunning REQ-028 gives the same result; in_valid held high during a busy period is not accepted.

Source files
------------

// File: rtl/complex_div.sv
// complex_div -- multi-cycle Q1.(W-1) complex divider, out = a*conj(b)/|b|^2.
// Sequence: IDLE -> MULT -> SUM -> DIV (restoring, W or W+1 cycles) -> DONE.
// Optional macro COMPLEX_DIV_RND_EN: one extra quotient bit, round half away
// from zero. Undefined: truncation toward zero.
module complex_div #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_in_i,
    input  logic signed [W-1:0] a_in_q,
    input  logic signed [W-1:0] b_in_i,
    input  logic signed [W-1:0] b_in_q,
    output logic signed [W-1:0] out_i,
    output logic signed [W-1:0] out_q,
    output logic                out_valid,
    output logic                sat,
    output logic                div_zero
);

`ifdef COMPLEX_DIV_RND_EN
    localparam int QW = W + 1;   // one guard bit for rounding
`else
    localparam int QW = W;
`endif
    localparam int NW = 2 * W + 1;             // numerator / remainder width
    localparam int CW = $clog2(QW + 1);

    localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};  // 2^(W-1)-1
    localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};  // 2^(W-1)
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MULT, SUM, DIV, DONE} state_t;

    state_t r_state, w_state_nxt;

    logic signed [W-1:0]   r_ai, r_aq, r_bi, r_bq;
    logic signed [2*W-1:0] r_p_ii, r_p_qq, r_p_qi, r_p_iq, r_sq_i, r_sq_q;
    logic [2*W-1:0]        r_den;
    logic [NW-1:0]         r_rem_i, r_rem_q;
    logic [QW-1:0]         r_quo_i, r_quo_q;
    logic                  r_neg_i, r_neg_q, r_ovf_i, r_ovf_q, r_zero;
    logic [CW-1:0]         r_cnt;
    logic signed [W-1:0]   r_out_i, r_out_q;
    logic                  r_out_valid, r_sat, r_div_zero;

    logic signed [NW-1:0]  w_num_i, w_num_q;
    logic [NW-1:0]         w_abs_i, w_abs_q;
    logic [2*W-1:0]        w_den;
    logic [NW:0]           w_step_i, w_step_q;
    logic [W:0]            w_mag_i, w_mag_q;
    logic [W:0]            w_fin_i, w_fin_q;
    logic                  w_div_last;

    // One restoring-division step: {quotient bit, shifted remainder}.
    function automatic logic [NW:0] div_step(input logic [NW-1:0] rem,
                                             input logic [NW-1:0] den);
        if (rem >= den)
            return {1'b1, NW'((rem - den) << 1)};
        else
            return {1'b0, NW'(rem << 1)};
    endfunction

    // Apply sign to a quotient magnitude and saturate: {sat flag, result}.
    function automatic logic [W:0] apply_sign(input logic [W:0] mag,
                                              input logic neg,
                                              input logic ovf);
        logic [W:0] res;
        if (neg) begin
            if (ovf || mag > NEG_LIM) res = {1'b1, MIN_VAL};
            else                      res = {1'b0, W'(-mag)};
        end else begin
            if (ovf || mag > POS_LIM) res = {1'b1, MAX_VAL};
            else                      res = {1'b0, mag[W-1:0]};
        end
        return res;
    endfunction

    // SUM-stage combinational terms: numerators, denominator, magnitudes.
    assign w_num_i = NW'(r_p_ii) + NW'(r_p_qq);
    assign w_num_q = NW'(r_p_qi) - NW'(r_p_iq);
    assign w_den   = $unsigned(r_sq_i) + $unsigned(r_sq_q);
    assign w_abs_i = w_num_i[NW-1] ? $unsigned(-w_num_i) : $unsigned(w_num_i);
    assign w_abs_q = w_num_q[NW-1] ? $unsigned(-w_num_q) : $unsigned(w_num_q);

    // DIV-stage step for both components against the shared denominator.
    assign w_step_i   = div_step(r_rem_i, NW'(r_den));
    assign w_step_q   = div_step(r_rem_q, NW'(r_den));
    assign w_div_last = (r_cnt == CW'(QW - 1));

    // DONE-stage quotient magnitude, rounded when the guard bit exists.
`ifdef COMPLEX_DIV_RND_EN
    assign w_mag_i = (W+1)'(({1'b0, r_quo_i} + (W+2)'(1)) >> 1);
    assign w_mag_q = (W+1)'(({1'b0, r_quo_q} + (W+2)'(1)) >> 1);
`else
    assign w_mag_i = {1'b0, r_quo_i};
    assign w_mag_q = {1'b0, r_quo_q};
`endif
    assign w_fin_i = apply_sign(w_mag_i, r_neg_i, r_ovf_i);
    assign w_fin_q = apply_sign(w_mag_q, r_neg_q, r_ovf_q);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    // NOTE: the default is assigned first so no path leaves w_state_nxt
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = MULT;
            MULT:    w_state_nxt = SUM;
            SUM:     w_state_nxt = DIV;
            DIV:     if (w_div_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, products, sums, division steps, outputs.
    // NOTE: datapath registers are reset too; there is no memory array here,
    // so clearing them is cheap and keeps reset state fully deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ai <= '0; r_aq <= '0; r_bi <= '0; r_bq <= '0;
            r_p_ii <= '0; r_p_qq <= '0; r_p_qi <= '0; r_p_iq <= '0;
            r_sq_i <= '0; r_sq_q <= '0;
            r_den <= '0; r_rem_i <= '0; r_rem_q <= '0;
            r_quo_i <= '0; r_quo_q <= '0;
            r_neg_i <= 1'b0; r_neg_q <= 1'b0;
            r_ovf_i <= 1'b0; r_ovf_q <= 1'b0; r_zero <= 1'b0;
            r_cnt <= '0;
            r_out_i <= '0; r_out_q <= '0;
            r_out_valid <= 1'b0; r_sat <= 1'b0; r_div_zero <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ai <= a_in_i; r_aq <= a_in_q;
                        r_bi <= b_in_i; r_bq <= b_in_q;
                    end
                end
                MULT: begin
                    r_p_ii <= r_ai * r_bi;
                    r_p_qq <= r_aq * r_bq;
                    r_p_qi <= r_aq * r_bi;
                    r_p_iq <= r_ai * r_bq;
                    r_sq_i <= r_bi * r_bi;
                    r_sq_q <= r_bq * r_bq;
                end
                SUM: begin
                    r_den   <= w_den;
                    r_rem_i <= w_abs_i;
                    r_rem_q <= w_abs_q;
                    r_neg_i <= w_num_i[NW-1];
                    r_neg_q <= w_num_q[NW-1];
                    r_zero  <= (w_den == '0);
                    r_ovf_i <= (w_abs_i >= {w_den, 1'b0});
                    r_ovf_q <= (w_abs_q >= {w_den, 1'b0});
                    r_quo_i <= '0;
                    r_quo_q <= '0;
                    r_cnt   <= '0;
                end
                DIV: begin
                    r_rem_i <= w_step_i[NW-1:0];
                    r_rem_q <= w_step_q[NW-1:0];
                    r_quo_i <= {r_quo_i[QW-2:0], w_step_i[NW]};
                    r_quo_q <= {r_quo_q[QW-2:0], w_step_q[NW]};
                    r_cnt   <= r_cnt + CW'(1);
                end
                DONE: begin
                    r_out_valid <= 1'b1;
                    if (r_zero) begin
                        r_out_i    <= '0;
                        r_out_q    <= '0;
                        r_sat      <= 1'b0;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_out_i    <= w_fin_i[W-1:0];
                        r_out_q    <= w_fin_q[W-1:0];
                        r_sat      <= w_fin_i[W] | w_fin_q[W];
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
    assign sat       = r_sat;
    assign div_zero  = r_div_zero;

endmodule
